// File: rtl/cpu_pkg.sv
// Shared definitions for the ALU result stage: opcodes, NZCV bit positions
// and the writeback FSM state encoding.
package cpu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_MUL = 4'd2;
    localparam logic [OP_W-1:0] OP_AND = 4'd3;
    localparam logic [OP_W-1:0] OP_OR  = 4'd4;
    localparam logic [OP_W-1:0] OP_XOR = 4'd5;
    localparam logic [OP_W-1:0] OP_NOT = 4'd6;
    localparam logic [OP_W-1:0] OP_ASL = 4'd7;
    localparam logic [OP_W-1:0] OP_ASR = 4'd8;
    localparam logic [OP_W-1:0] OP_LSL = 4'd9;
    localparam logic [OP_W-1:0] OP_LSR = 4'd10;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // EMPTY: nothing held; ONE: single result (or MUL high half) held;
    // LO: MUL low half held with the high half queued behind it.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        LO    = 2'd2
    } stageState_t;

    // Opcodes 11..15 have no ALU result behind them.
    function automatic logic isLegalOp(input logic [OP_W-1:0] op);
        return (op <= OP_LSR);
    endfunction

endpackage

// File: rtl/alu_flag_calc.sv
// Combinational NZCV computation for the op being accepted. C and V are
// only defined by ADD and SUB; every other op passes the held values through.
module alu_flag_calc
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic [OP_W-1:0]  i_op,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic [WIDTH-1:0] i_res,
    input  logic [WIDTH-1:0] i_multHi,
    input  logic             i_carry,
    input  logic [3:0]       i_flags,
    output logic [3:0]       o_flags
);

    // Start from the held flags and overwrite only the bits this op defines
    always_comb begin
        o_flags = i_flags;
        case (i_op)
            OP_ADD: begin
                o_flags[FLAG_N] = i_res[WIDTH-1];
                o_flags[FLAG_Z] = (i_res == '0);
                o_flags[FLAG_C] = i_carry;
                o_flags[FLAG_V] = (i_x[WIDTH-1] == i_y[WIDTH-1]) &&
                                  (i_res[WIDTH-1] != i_x[WIDTH-1]);
            end
            OP_SUB: begin
                o_flags[FLAG_N] = i_res[WIDTH-1];
                o_flags[FLAG_Z] = (i_res == '0);
                o_flags[FLAG_C] = (i_x >= i_y);
                o_flags[FLAG_V] = (i_x[WIDTH-1] != i_y[WIDTH-1]) &&
                                  (i_res[WIDTH-1] != i_x[WIDTH-1]);
            end
            OP_MUL: begin
                o_flags[FLAG_N] = i_multHi[WIDTH-1];
                o_flags[FLAG_Z] = (i_multHi == '0) && (i_res == '0);
            end
            default: begin
                if (isLegalOp(i_op)) begin
                    o_flags[FLAG_N] = i_res[WIDTH-1];
                    o_flags[FLAG_Z] = (i_res == '0);
                end
            end
        endcase
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered stage behind the combinational ALU. Selects the result by
// opcode, keeps the NZCV flags and hands results to the register file over
// valid/ready, splitting MUL into a low-half then a high-half writeback.
module alu_result_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int RA_W  = 4
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [RA_W-1:0]  in_rd,
    input  logic [RA_W-1:0]  in_rd_hi,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] summ,
    input  logic [WIDTH-1:0] sub,
    input  logic [WIDTH-1:0] mult_h,
    input  logic [WIDTH-1:0] mult_l,
    input  logic             ocarry,
    input  logic [WIDTH-1:0] zand,
    input  logic [WIDTH-1:0] zor,
    input  logic [WIDTH-1:0] zxor,
    input  logic [WIDTH-1:0] znot,
    input  logic [WIDTH-1:0] ashiftl,
    input  logic [WIDTH-1:0] ashiftr,
    input  logic [WIDTH-1:0] lshiftl,
    input  logic [WIDTH-1:0] lshiftr,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [RA_W-1:0]  wb_addr,
    output logic [WIDTH-1:0] wb_data,
    output logic [3:0]       flags
);

    stageState_t      r_state;
    stageState_t      w_nextState;
    stageState_t      w_acceptState;
    logic [RA_W-1:0]  r_wbAddr;
    logic [RA_W-1:0]  r_rdhiQ;
    logic [WIDTH-1:0] r_wbData;
    logic [WIDTH-1:0] r_hiQ;
    logic [3:0]       r_flags;
    logic [WIDTH-1:0] w_result;
    logic [3:0]       w_nextFlags;
    logic             w_accept;
    logic             w_legal;
    logic             w_isMul;

    assign w_accept = in_valid && in_ready;
    assign w_legal  = isLegalOp(in_op);
    assign w_isMul  = (in_op == OP_MUL);

    // Illegal ops are swallowed without a writeback; MUL queues two writebacks
    assign w_acceptState = !w_legal ? EMPTY : (w_isMul ? LO : ONE);

    assign wb_addr = r_wbAddr;
    assign wb_data = r_wbData;
    assign flags   = r_flags;

    // Pick the ALU output matching the opcode; MUL presents its low half first
    always_comb begin
        w_result = '0;
        case (in_op)
            OP_ADD:  w_result = summ;
            OP_SUB:  w_result = sub;
            OP_MUL:  w_result = mult_l;
            OP_AND:  w_result = zand;
            OP_OR:   w_result = zor;
            OP_XOR:  w_result = zxor;
            OP_NOT:  w_result = znot;
            OP_ASL:  w_result = ashiftl;
            OP_ASR:  w_result = ashiftr;
            OP_LSL:  w_result = lshiftl;
            OP_LSR:  w_result = lshiftr;
            default: w_result = '0;
        endcase
    end

    alu_flag_calc #(
        .WIDTH(WIDTH)
    ) u_flagCalc (
        .i_op     (in_op),
        .i_x      (x),
        .i_y      (y),
        .i_res    (w_result),
        .i_multHi (mult_h),
        .i_carry  (ocarry),
        .i_flags  (r_flags),
        .o_flags  (w_nextFlags)
    );

    // FSM state register; reset abandons any pending MUL high half
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: accepting in ONE replaces the outgoing result in the same edge
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_nextState = w_acceptState;
                end
            end
            ONE: begin
                if (w_accept) begin
                    w_nextState = w_acceptState;
                end else if (wb_ready) begin
                    w_nextState = EMPTY;
                end
            end
            LO: begin
                if (wb_ready) begin
                    w_nextState = ONE;
                end
            end
            default: w_nextState = EMPTY;
        endcase
    end

    // Handshake outputs depend only on state and wb_ready, never on in_valid
    always_comb begin
        wb_valid = (r_state != EMPTY);
        in_ready = (r_state == EMPTY) || ((r_state == ONE) && wb_ready);
    end

    // Writeback, high-half and flag registers; outputs hold while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wbAddr <= '0;
            r_wbData <= '0;
            r_hiQ    <= '0;
            r_rdhiQ  <= '0;
            r_flags  <= '0;
        end else if (w_accept && w_legal) begin
            r_wbAddr <= in_rd;
            r_wbData <= w_result;
            r_flags  <= w_nextFlags;
            if (w_isMul) begin
                r_hiQ   <= mult_h;
                r_rdhiQ <= in_rd_hi;
            end
        end else if ((r_state == LO) && wb_ready) begin
            r_wbAddr <= r_rdhiQ;
            r_wbData <= r_hiQ;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage. Models the upstream ALU, then
// predicts writebacks with a queue of pending (addr, data) pairs and the
// flags from plain signed/unsigned arithmetic.
module tb_alu_result_stage;
    import cpu_pkg::*;

    localparam int WIDTH = 32;
    localparam int RA_W  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [RA_W-1:0]  in_rd;
    logic [RA_W-1:0]  in_rd_hi;
    logic [WIDTH-1:0] x, y, summ, sub, mult_h, mult_l;
    logic             ocarry;
    logic [WIDTH-1:0] zand, zor, zxor, znot;
    logic [WIDTH-1:0] ashiftl, ashiftr, lshiftl, lshiftr;
    logic             wb_valid;
    logic             wb_ready;
    logic [RA_W-1:0]  wb_addr;
    logic [WIDTH-1:0] wb_data;
    logic [3:0]       flags;

    typedef struct packed {
        logic [RA_W-1:0]  addr;
        logic [WIDTH-1:0] data;
    } wbEntry_t;

    wbEntry_t   expQ[$];
    logic [3:0] expFlags;
    bit         freshReset;
    int         nChecks = 0;
    int         nFails  = 0;

    always #5 clk = ~clk;

    alu_result_stage #(
        .WIDTH(WIDTH),
        .RA_W (RA_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_rd    (in_rd),
        .in_rd_hi (in_rd_hi),
        .x        (x),
        .y        (y),
        .summ     (summ),
        .sub      (sub),
        .mult_h   (mult_h),
        .mult_l   (mult_l),
        .ocarry   (ocarry),
        .zand     (zand),
        .zor      (zor),
        .zxor     (zxor),
        .znot     (znot),
        .ashiftl  (ashiftl),
        .ashiftr  (ashiftr),
        .lshiftl  (lshiftl),
        .lshiftr  (lshiftr),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .flags    (flags)
    );

    // One comparison: count it and report a mismatch
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Behaviour of the ALU for a single-word result
    function automatic logic [31:0] aluRef(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic cin);
        logic [31:0] r;
        case (op)
            4'd0:    r = a + b + {31'd0, cin};
            4'd1:    r = a - b;
            4'd3:    r = a & b;
            4'd4:    r = a | b;
            4'd5:    r = a ^ b;
            4'd6:    r = ~a;
            4'd7:    r = a << b[4:0];
            4'd8:    r = $signed(a) >>> b[4:0];
            4'd9:    r = a << b[4:0];
            4'd10:   r = a >> b[4:0];
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Drive every ALU output as the real ALU would for these operands
    task automatic driveAlu(input logic [31:0] a, input logic [31:0] b, input logic cin);
        logic [32:0] wide;
        logic [63:0] prod;
        wide    = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        prod    = {32'd0, a} * {32'd0, b};
        x       = a;
        y       = b;
        summ    = wide[31:0];
        ocarry  = wide[32];
        sub     = aluRef(4'd1, a, b, cin);
        mult_h  = prod[63:32];
        mult_l  = prod[31:0];
        zand    = aluRef(4'd3, a, b, cin);
        zor     = aluRef(4'd4, a, b, cin);
        zxor    = aluRef(4'd5, a, b, cin);
        znot    = aluRef(4'd6, a, b, cin);
        ashiftl = aluRef(4'd7, a, b, cin);
        ashiftr = aluRef(4'd8, a, b, cin);
        lshiftl = aluRef(4'd9, a, b, cin);
        lshiftr = aluRef(4'd10, a, b, cin);
    endtask

    // One cycle: drive inputs, check outputs against the model, advance the model
    task automatic applyStimulus(input logic r, input logic v, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b, input logic cin,
                                 input logic [3:0] rd, input logic [3:0] rdhi, input logic wr);
        bit          expReady;
        logic [32:0] wide;
        logic [63:0] prod;
        logic [31:0] res;
        longint      sres;
        rst      = r;
        in_valid = v;
        in_op    = op;
        in_rd    = rd;
        in_rd_hi = rdhi;
        wb_ready = wr;
        driveAlu(a, b, cin);
        #1;
        expReady = (expQ.size() == 0) || ((expQ.size() == 1) && wr);
        checkOutput("in_ready", {63'd0, in_ready}, {63'd0, expReady});
        checkOutput("wb_valid", {63'd0, wb_valid}, {63'd0, expQ.size() != 0});
        checkOutput("flags", {60'd0, flags}, {60'd0, expFlags});
        if (expQ.size() != 0) begin
            checkOutput("wb_addr", {60'd0, wb_addr}, {60'd0, expQ[0].addr});
            checkOutput("wb_data", {32'd0, wb_data}, {32'd0, expQ[0].data});
        end else if (freshReset) begin
            checkOutput("wb_addr_rst", {60'd0, wb_addr}, 64'd0);
            checkOutput("wb_data_rst", {32'd0, wb_data}, 64'd0);
        end
        @(posedge clk);
        if (r) begin
            expQ.delete();
            expFlags   = 4'd0;
            freshReset = 1'b1;
        end else begin
            if ((expQ.size() != 0) && wr) begin
                void'(expQ.pop_front());
            end
            if (v && expReady && (op <= 4'd10)) begin
                freshReset = 1'b0;
                if (op == 4'd2) begin
                    prod = {32'd0, a} * {32'd0, b};
                    expQ.push_back('{addr: rd, data: prod[31:0]});
                    expQ.push_back('{addr: rdhi, data: prod[63:32]});
                    expFlags[FLAG_N] = prod[63];
                    expFlags[FLAG_Z] = (prod == 64'd0);
                end else begin
                    res = aluRef(op, a, b, cin);
                    expQ.push_back('{addr: rd, data: res});
                    expFlags[FLAG_N] = res[31];
                    expFlags[FLAG_Z] = (res == 32'd0);
                    if (op == 4'd0) begin
                        wide = {1'b0, a} + {1'b0, b} + {32'd0, cin};
                        sres = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
                        expFlags[FLAG_C] = wide[32];
                        expFlags[FLAG_V] = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
                    end else if (op == 4'd1) begin
                        sres = longint'($signed(a)) - longint'($signed(b));
                        expFlags[FLAG_C] = (a >= b);
                        expFlags[FLAG_V] = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    // Operand picker biased toward sign/overflow corner values
    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Directed scenarios first, then randomized traffic with random back-pressure
    initial begin
        logic [3:0] op;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_op    = 4'd0;
        in_rd    = '0;
        in_rd_hi = '0;
        wb_ready = 1'b0;
        driveAlu(32'd0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        expQ.delete();
        expFlags   = 4'd0;
        freshReset = 1'b1;

        // reset state and ADD with carry-in 0 / 1
        applyStimulus(0, 0, 4'd0, 32'd0, 32'd0, 0, 4'd0, 4'd0, 1);
        applyStimulus(0, 1, 4'd0, 32'd2, 32'd6, 0, 4'd1, 4'd0, 1);
        applyStimulus(0, 1, 4'd0, 32'd2, 32'd6, 1, 4'd2, 4'd0, 1);
        // ADD carry-out and signed overflow
        applyStimulus(0, 1, 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 4'd5, 4'd0, 1);
        applyStimulus(0, 1, 4'd0, 32'h7FFF_FFFF, 32'd1, 0, 4'd6, 4'd0, 1);
        // MUL split into two writebacks; an offered ADD must wait
        applyStimulus(0, 1, 4'd2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 4'd3, 4'd4, 1);
        applyStimulus(0, 1, 4'd0, 32'd1, 32'd1, 0, 4'd7, 4'd0, 1);
        applyStimulus(0, 0, 4'd0, 32'd0, 32'd0, 0, 4'd0, 4'd0, 1);
        // SUB then AND keeping C
        applyStimulus(0, 1, 4'd1, 32'd10, 32'hFFFF_FFEC, 0, 4'd8, 4'd0, 1);
        applyStimulus(0, 1, 4'd3, 32'h3333_3333, 32'hF0A5_C96B, 0, 4'd9, 4'd0, 1);
        // stall for three cycles, then release into back-to-back accepts
        applyStimulus(0, 1, 4'd0, 32'd100, 32'd23, 0, 4'd10, 4'd0, 1);
        repeat (3) applyStimulus(0, 1, 4'd5, 32'hDEAD_BEEF, 32'h1234_5678, 0, 4'd11, 4'd0, 0);
        applyStimulus(0, 1, 4'd5, 32'hDEAD_BEEF, 32'h1234_5678, 0, 4'd11, 4'd0, 1);
        applyStimulus(0, 1, 4'd4, 32'h0F0F_0000, 32'h0000_F0F0, 0, 4'd12, 4'd0, 1);
        applyStimulus(0, 0, 4'd0, 32'd0, 32'd0, 0, 4'd0, 4'd0, 1);
        // reset while the MUL high half is pending, then an illegal op
        applyStimulus(0, 1, 4'd2, 32'h0001_0000, 32'h0003_0000, 0, 4'd13, 4'd14, 0);
        applyStimulus(1, 0, 4'd0, 32'd0, 32'd0, 0, 4'd0, 4'd0, 1);
        applyStimulus(0, 1, 4'd0, 32'h8000_0000, 32'h8000_0000, 0, 4'd1, 4'd0, 1);
        applyStimulus(0, 1, 4'd12, 32'd5, 32'd5, 0, 4'd2, 4'd3, 1);
        repeat (2) applyStimulus(0, 0, 4'd0, 32'd0, 32'd0, 0, 4'd0, 4'd0, 1);

        for (int i = 0; i < 600; i++) begin
            op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(11, 15))
                                             : 4'($urandom_range(0, 10));
            applyStimulus(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0), op,
                          pickOperand(), pickOperand(), 1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          ($urandom_range(0, 3) != 0));
        end

        $display("[TB] random phase complete");
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered stage directly downstream of the combinational `ALU`. It accepts one operation per handshake and selects the matching ALU output by opcode. It computes and holds the NZCV flags, which the ALU leaves to an outer module. It presents register-file writebacks over a valid/ready interface, splitting MUL into two writebacks: low half, then high half.

## Interface
- `WIDTH`, 32, datapath width; must match the ALU.
- `RA_W`, 4, register address width.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream has an op and stable ALU outputs.
- `in_ready`  out  1  stage accepts this cycle.
- `in_op`  in  4  0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 XOR, 6 NOT, 7 ASL, 8 ASR, 9 LSL, 10 LSR; 11–15 illegal.
- `in_rd`  in  RA_W  destination; receives the MUL low half.
- `in_rd_hi`  in  RA_W  MUL high-half destination; ignored for other ops.
- `x`, `y`  in  WIDTH  ALU operands; used for the V flag and the SUB carry.
- `summ`, `sub`, `mult_h`, `mult_l`  in  WIDTH  ALU arithmetic results.
- `ocarry`  in  1  ALU adder carry-out.
- `zand`, `zor`, `zxor`, `znot`  in  WIDTH  ALU logic results.
- `ashiftl`, `ashiftr`, `lshiftl`, `lshiftr`  in  WIDTH  ALU shift results.
- `wb_valid`  out  1  writeback pending.
- `wb_ready`  in  1  register file takes the writeback this cycle.
- `wb_addr`  out  RA_W  writeback register.
- `wb_data`  out  WIDTH  writeback value.
- `flags`  out  4  {N,Z,C,V}, registered.

## Operation
- States:
  - `EMPTY`: holds no writeback.
  - `ONE`: single result held, or MUL high half held.
  - `LO`: MUL low half held, high half pending in `hi_q`/`rdhi_q`.
- Accept rule: an op is accepted when `in_valid && in_ready`.
- `in_ready = (state==EMPTY) || (state==ONE && wb_ready)`.
  - Low in `LO`.
  - Combinational from state and `wb_ready` only; never depends on `in_valid`.
- Transitions on accept:
  - Legal non-MUL: to `ONE`.
  - MUL: to `LO`.
  - Illegal op: to `EMPTY`, no writeback, flags unchanged.
- Other transitions:
  - `LO` + `wb_ready` → `ONE`, with `wb_addr/wb_data` loaded from `rdhi_q/hi_q`.
  - `ONE` + `wb_ready` without accept → `EMPTY`.
- Flags update on the accept edge:
  - ADD: N=`summ[31]`, Z=(`summ`==0), C=`ocarry`, V=(x[31]==y[31])&&(summ[31]!=x[31]).
  - SUB: N/Z from `sub`, C=(x>=y) unsigned (no-borrow), V=(x[31]!=y[31])&&(sub[31]!=x[31]).
  - MUL: N=`mult_h[31]`, Z=(`mult_h`==0 && `mult_l`==0); C, V unchanged.
  - Logic/shift ops: N/Z from the selected result; C, V unchanged.
- Carry-in for ADD is driven into the ALU upstream; this stage only reads `summ`/`ocarry`.

## Timing
- Reset values:
  - state `EMPTY`; `wb_valid`=0; `wb_addr`=0; `wb_data`=0; `flags`=0; `hi_q`=0; `rdhi_q`=0.
  - `in_ready`=1 in the cycle after reset.
- Reset during `LO` discards the pending high half.
- Latency:
  - Accept at edge N → `wb_valid`=1 from cycle N+1 and the new flags are visible in cycle N+1.
  - MUL high half is presented the cycle after the low half handshakes.
- Throughput: one non-MUL op per cycle under continuous `wb_ready`; MUL takes 2 cycles.
- Outputs hold stable while `wb_valid && !wb_ready`.
- Simultaneous handshake-out and accept in `ONE`: the new result replaces the old in the same edge with no bubble.

## Structure
- Shared package `cpu_pkg`:
  - opcode localparams: `OP_ADD`…`OP_LSR`
  - flag bit indices: `FLAG_N=3`, `FLAG_Z=2`, `FLAG_C=1`, `FLAG_V=0`
  - state encoding
- One sub-module `alu_flag_calc`: combinational NZCV computation from op, operands and the selected result.
- Result mux and FSM live in the top module.

## Test plan
- ADD, x=2, y=6, carry-in 0, `wb_ready`=1 → `wb_data`=8, flags=0000; repeat with carry-in 1 → `wb_data`=9, C=0.
- ADD, x=y=0xFFFFFFFF → `wb_data`=0xFFFFFFFE, flags N=1 C=1 Z=0 V=0; separately x=0x7FFFFFFF, y=1 → N=1, V=1.
- MUL, x=y=0x7FFFFFFF, rd=3, rd_hi=4 → writeback (3, 0x00000001) then (4, 0x3FFFFFFF); `in_ready`=0 in the cycle between them.
- SUB, x=10, y=-20 → `wb_data`=30, C=0, V=0, N=0; then AND with 0x33333333 / 0xF0A5C96B → 0x30210123, C unchanged.
- Hold `wb_ready`=0 for 3 cycles after an ADD → `wb_data`/`wb_addr` stable and `in_ready`=0; release with a new op valid → back-to-back accept, no bubble.
- Assert `rst` while in `LO` → next cycle `wb_valid`=0, flags=0, and the high half is never written; op 12 accepted → no writeback, flags unchanged.
